// File: rtl/core_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the pipeline sequencing logic of the 5-stage core.
//   ctrl_state_t : sequencer states (RUN, DRAIN, HALTED)
//   ECALL_X17    : architectural register an ecall reads for its service code
//   HALT_CODE    : service code in x17 that requests a halt
//   reg_match()  : "this source really reads the producer's rd" helper
// ----------------------------------------------------------------------------
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam logic [4:0]  ECALL_X17 = 5'd17;
    localparam logic [31:0] HALT_CODE = 32'd10;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // A source depends on a producer only if it is really read and the
    // producer targets a real register (x0 writes are discarded).
    function automatic logic reg_match(
        input logic [4:0] src,
        input logic       src_used,
        input logic [4:0] prod_rd
    );
        return src_used & (prod_rd != REG_ZERO) & (src == prod_rd);
    endfunction

endpackage : core_ctrl_pkg

// File: rtl/hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational detection of the hazards forwarding cannot resolve.
//   Inputs : ID source registers and use flags, ID ecall flag, EX rd with its
//            load/write flags, MEM rd with its load flag.
//   Outputs: load_use_o  - ID reads the destination of a load now in EX.
//            ecall_haz_o - ID ecall needs x17 that is not yet forwardable
//                          (written by EX, or loaded by MEM).
// ----------------------------------------------------------------------------
module hazard_detect
    import core_ctrl_pkg::*;
#(
    parameter logic [4:0] ECALL_REG = ECALL_X17
) (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       id_is_ecall_i,
    input  logic [4:0] id_ex_rd_i,
    input  logic       id_ex_mem_read_i,
    input  logic       id_ex_reg_write_i,
    input  logic [4:0] ex_mem_rd_i,
    input  logic       ex_mem_mem_read_i,
    output logic       load_use_o,
    output logic       ecall_haz_o
);

    logic rs1_dep_s;
    logic rs2_dep_s;
    logic x17_ex_s;
    logic x17_mem_s;

    assign rs1_dep_s = reg_match(id_rs1_i, id_use_rs1_i, id_ex_rd_i);
    assign rs2_dep_s = reg_match(id_rs2_i, id_use_rs2_i, id_ex_rd_i);

    // The ecall operand is treated as an always-used source so an rd of x0
    // can never stall it, even if ECALL_REG were ever set to zero.
    assign x17_ex_s  = id_ex_reg_write_i & reg_match(ECALL_REG, 1'b1, id_ex_rd_i);
    assign x17_mem_s = ex_mem_mem_read_i & reg_match(ECALL_REG, 1'b1, ex_mem_rd_i);

    assign load_use_o  = id_ex_mem_read_i & (rs1_dep_s | rs2_dep_s);
    assign ecall_haz_o = id_is_ecall_i & (x17_ex_s | x17_mem_s);

endmodule : hazard_detect

// File: rtl/hazard_stall_controller.sv
// ----------------------------------------------------------------------------
// hazard_stall_controller
// Central pipeline sequencer: decides each cycle whether the pipeline
// registers advance, stall, take a bubble or flush, sequences the halt drain
// after a halting ecall, and keeps saturating stall / flush counters.
//   clk, reset           : core clock, asynchronous active-low reset
//   id_*                 : ID-stage sources, use flags, ecall / halt request
//   id_ex_*, ex_mem_*    : destination info of the EX and MEM occupants
//   ex_mispredict        : EX resolved a branch/jump wrongly this cycle
//   dmem_req, dmem_ready : data-cache handshake; req & !ready freezes all
//   pc_write .. mem_wb_bubble : pipeline latch enables / NOP injects
//   is_halted            : core has retired its halting ecall
//   stall_cycles         : RUN cycles with pc_write low (saturating)
//   flush_count          : mispredict flushes taken (saturating)
// Latch controls are combinational from the current state and inputs; the
// state, drain counter and performance counters are registered.
// ----------------------------------------------------------------------------
module hazard_stall_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned ECALL_REG    = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 id_is_ecall,
    input  logic                 id_halt_req,
    input  logic [4:0]           id_ex_rd,
    input  logic                 id_ex_mem_read,
    input  logic                 id_ex_reg_write,
    input  logic [4:0]           ex_mem_rd,
    input  logic                 ex_mem_mem_read,
    input  logic                 ex_mispredict,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_write,
    output logic                 mem_wb_bubble,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int unsigned DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);
    localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

    ctrl_state_t          state_q, state_d;
    logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze_s;
    logic load_use_s;
    logic ecall_haz_s;
    logic flush_take_s;

    logic pc_write_s;
    logic if_id_write_s;
    logic if_id_flush_s;
    logic id_ex_write_s;
    logic id_ex_bubble_s;
    logic ex_mem_write_s;
    logic mem_wb_bubble_s;
    logic is_halted_s;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : (v + {{(CNT_WIDTH-1){1'b0}}, 1'b1});
    endfunction

    assign freeze_s = dmem_req & ~dmem_ready;

    hazard_detect #(
        .ECALL_REG (5'(ECALL_REG))
    ) u_hazard_detect (
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_use_rs1_i      (id_use_rs1),
        .id_use_rs2_i      (id_use_rs2),
        .id_is_ecall_i     (id_is_ecall),
        .id_ex_rd_i        (id_ex_rd),
        .id_ex_mem_read_i  (id_ex_mem_read),
        .id_ex_reg_write_i (id_ex_reg_write),
        .ex_mem_rd_i       (ex_mem_rd),
        .ex_mem_mem_read_i (ex_mem_mem_read),
        .load_use_o        (load_use_s),
        .ecall_haz_o       (ecall_haz_s)
    );

    // Latch controls and next state, selected by state and hazard priority.
    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        flush_take_s    = 1'b0;
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_write_s   = 1'b1;
        id_ex_bubble_s  = 1'b0;
        ex_mem_write_s  = 1'b1;
        mem_wb_bubble_s = 1'b0;
        is_halted_s     = 1'b0;

        case (state_q)
            RUN: begin
                if (freeze_s) begin
                    // EX holds, so a pending mispredict or halt re-presents
                    // once the cache answers.
                    pc_write_s      = 1'b0;
                    if_id_write_s   = 1'b0;
                    id_ex_write_s   = 1'b0;
                    ex_mem_write_s  = 1'b0;
                    mem_wb_bubble_s = 1'b1;
                end else if (ex_mispredict) begin
                    // The flush discards the ID occupant, so any load-use on
                    // it is moot and does not count as a stall.
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    flush_take_s   = 1'b1;
                end else if (load_use_s | ecall_haz_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                end else if (id_halt_req) begin
                    // Let the ecall advance, stop fetching, then drain.
                    pc_write_s    = 1'b0;
                    if_id_flush_s = 1'b1;
                    state_d       = DRAIN;
                    drain_cnt_d   = DRAIN_LOAD;
                end else begin
                    state_d = RUN;
                end
            end

            DRAIN: begin
                pc_write_s = 1'b0;
                if (freeze_s) begin
                    if_id_write_s   = 1'b0;
                    id_ex_write_s   = 1'b0;
                    ex_mem_write_s  = 1'b0;
                    mem_wb_bubble_s = 1'b1;
                end else begin
                    // Only younger work is behind the ecall, so a mispredict
                    // signal here cannot be genuine and is ignored.
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    drain_cnt_d    = drain_cnt_q - DRAIN_ONE;
                    if (drain_cnt_q == DRAIN_ONE) begin
                        state_d = HALTED;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            HALTED: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                id_ex_write_s  = 1'b0;
                ex_mem_write_s = 1'b0;
                is_halted_s    = 1'b1;
            end

            default: begin
                // Unreachable encoding: recover to RUN with a clean count.
                state_d     = RUN;
                drain_cnt_d = {DCW{1'b0}};
            end
        endcase
    end

    // Performance counters advance only while running.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == RUN) begin
            if (!pc_write_s) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_take_s) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, drain counter and performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            drain_cnt_q <= {DCW{1'b0}};
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
            flush_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_write      = pc_write_s;
    assign if_id_write   = if_id_write_s;
    assign if_id_flush   = if_id_flush_s;
    assign id_ex_write   = id_ex_write_s;
    assign id_ex_bubble  = id_ex_bubble_s;
    assign ex_mem_write  = ex_mem_write_s;
    assign mem_wb_bubble = mem_wb_bubble_s;
    assign is_halted     = is_halted_s;
    assign stall_cycles  = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule : hazard_stall_controller

// File: tb/tb_hazard_stall_controller.sv
// ----------------------------------------------------------------------------
// tb_hazard_stall_controller
// Directed vectors drive the controller one cycle at a time; each vector's
// hand-computed expected controls and counter values go into a queue, and a
// monitor on the falling edge pops and compares them.
// Control vector bit order:
//   {pc_write, if_id_write, if_id_flush, id_ex_write,
//    id_ex_bubble, ex_mem_write, mem_wb_bubble, is_halted}
// Counter expectations are the values visible during the cycle, i.e. before
// that cycle's own update takes effect.
// ----------------------------------------------------------------------------
module tb_hazard_stall_controller;

    localparam logic [7:0] P_RUN    = 8'b1101_0100;
    localparam logic [7:0] P_FREEZE = 8'b0000_0010;
    localparam logic [7:0] P_MISP   = 8'b1111_1100;
    localparam logic [7:0] P_STALL  = 8'b0001_1100;
    localparam logic [7:0] P_HALTGO = 8'b0111_0100;
    localparam logic [7:0] P_DRAIN  = 8'b0111_1100;
    localparam logic [7:0] P_HALTED = 8'b0000_0001;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       ecall;
        logic       halt;
        logic [4:0] ex_rd;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] mem_rd;
        logic       mem_mr;
        logic       misp;
        logic       dreq;
        logic       drdy;
    } in_t;

    typedef struct {
        string       name;
        logic [7:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd, ex_mem_rd;
    logic        id_use_rs1, id_use_rs2, id_is_ecall, id_halt_req;
    logic        id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic        ex_mispredict, dmem_req, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_bubble, ex_mem_write, mem_wb_bubble, is_halted;
    logic [31:0] stall_cycles, flush_count;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    hazard_stall_controller #(
        .DRAIN_CYCLES (3),
        .CNT_WIDTH    (32),
        .ECALL_REG    (17)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_is_ecall     (id_is_ecall),
        .id_halt_req     (id_halt_req),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_reg_write (id_ex_reg_write),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_mem_read (ex_mem_mem_read),
        .ex_mispredict   (ex_mispredict),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_bubble   (mem_wb_bubble),
        .is_halted       (is_halted),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t v;
        v.rst    = 1'b1;
        v.rs1    = 5'd0;
        v.rs2    = 5'd0;
        v.use1   = 1'b0;
        v.use2   = 1'b0;
        v.ecall  = 1'b0;
        v.halt   = 1'b0;
        v.ex_rd  = 5'd0;
        v.ex_mr  = 1'b0;
        v.ex_rw  = 1'b0;
        v.mem_rd = 5'd0;
        v.mem_mr = 1'b0;
        v.misp   = 1'b0;
        v.dreq   = 1'b0;
        v.drdy   = 1'b0;
        return v;
    endfunction

    task automatic apply(input in_t v);
        reset           = v.rst;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_use_rs1      = v.use1;
        id_use_rs2      = v.use2;
        id_is_ecall     = v.ecall;
        id_halt_req     = v.halt;
        id_ex_rd        = v.ex_rd;
        id_ex_mem_read  = v.ex_mr;
        id_ex_reg_write = v.ex_rw;
        ex_mem_rd       = v.mem_rd;
        ex_mem_mem_read = v.mem_mr;
        ex_mispredict   = v.misp;
        dmem_req        = v.dreq;
        dmem_ready      = v.drdy;
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue its
    // expected response.
    task automatic step(input in_t v, input logic [7:0] ctl,
                        input logic [31:0] sc, input logic [31:0] fc,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.name = name;
        e.ctl  = ctl;
        e.sc   = sc;
        e.fc   = fc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the oldest expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {pc_write, if_id_write, if_id_flush, id_ex_write,
                       id_ex_bubble, ex_mem_write, mem_wb_bubble, is_halted};
                checks = checks + 1;
                if (act !== e.ctl) begin
                    errors = errors + 1;
                    $display("FAIL %s ctl got %b want %b", e.name, act, e.ctl);
                end
                checks = checks + 1;
                if (stall_cycles !== e.sc) begin
                    errors = errors + 1;
                    $display("FAIL %s stall_cycles got %0d want %0d", e.name, stall_cycles, e.sc);
                end
                checks = checks + 1;
                if (flush_count !== e.fc) begin
                    errors = errors + 1;
                    $display("FAIL %s flush_count got %0d want %0d", e.name, flush_count, e.fc);
                end
            end
        end
    end

    initial begin
        in_t v;
        checks = 0;
        errors = 0;
        v = idle();
        v.rst = 1'b0;
        apply(v);

        // Reset state
        step(v, P_RUN, 32'd0, 32'd0, "reset0");
        step(v, P_RUN, 32'd0, 32'd0, "reset1");
        v = idle();
        step(v, P_RUN, 32'd0, 32'd0, "idle");

        // Load-use: EX lw x5, ID add x6,x5,x1
        v = idle(); v.ex_rd = 5'd5; v.ex_mr = 1'b1; v.ex_rw = 1'b1;
        v.rs1 = 5'd5; v.use1 = 1'b1; v.rs2 = 5'd1; v.use2 = 1'b1;
        step(v, P_STALL, 32'd0, 32'd0, "load_use");
        v = idle(); v.mem_rd = 5'd5; v.mem_mr = 1'b1;
        v.rs1 = 5'd5; v.use1 = 1'b1; v.rs2 = 5'd1; v.use2 = 1'b1;
        step(v, P_RUN, 32'd1, 32'd0, "load_use_after");

        // rd = x0 producer, and a matching but unused rs2
        v = idle(); v.ex_rd = 5'd0; v.ex_mr = 1'b1; v.rs1 = 5'd0; v.use1 = 1'b1;
        step(v, P_RUN, 32'd1, 32'd0, "rd_zero");
        v = idle(); v.ex_rd = 5'd5; v.ex_mr = 1'b1; v.rs1 = 5'd3; v.use1 = 1'b1;
        v.rs2 = 5'd5; v.use2 = 1'b0;
        step(v, P_RUN, 32'd1, 32'd0, "unused_rs2");

        // Mispredict together with load-use
        v = idle(); v.ex_rd = 5'd5; v.ex_mr = 1'b1; v.rs1 = 5'd5; v.use1 = 1'b1;
        v.misp = 1'b1;
        step(v, P_MISP, 32'd1, 32'd0, "misp_and_lu");
        v = idle();
        step(v, P_RUN, 32'd1, 32'd1, "misp_after");

        // Ecall hazards: MEM lw x17, then EX addi x17
        v = idle(); v.ecall = 1'b1; v.mem_rd = 5'd17; v.mem_mr = 1'b1;
        step(v, P_STALL, 32'd1, 32'd1, "ecall_mem_lw");
        v = idle(); v.ecall = 1'b1; v.mem_rd = 5'd17;
        step(v, P_RUN, 32'd2, 32'd1, "ecall_mem_go");
        v = idle(); v.ecall = 1'b1; v.ex_rd = 5'd17; v.ex_rw = 1'b1;
        step(v, P_STALL, 32'd2, 32'd1, "ecall_ex_addi");
        v = idle(); v.ecall = 1'b1; v.mem_rd = 5'd17;
        step(v, P_RUN, 32'd3, 32'd1, "ecall_ex_go");

        // Freeze outranks a mispredict, which is then taken next cycle
        v = idle(); v.dreq = 1'b1; v.drdy = 1'b0; v.misp = 1'b1;
        step(v, P_FREEZE, 32'd3, 32'd1, "freeze_misp");
        v = idle(); v.dreq = 1'b1; v.drdy = 1'b1; v.misp = 1'b1;
        step(v, P_MISP, 32'd4, 32'd1, "misp_after_freeze");

        // Halt with four frozen cycles inside the drain
        v = idle(); v.ecall = 1'b1; v.halt = 1'b1;
        step(v, P_HALTGO, 32'd4, 32'd2, "halt_go");
        v = idle(); v.dreq = 1'b1;
        step(v, P_FREEZE, 32'd5, 32'd2, "drain_frz1");
        step(v, P_FREEZE, 32'd5, 32'd2, "drain_frz2");
        v = idle(); v.misp = 1'b1;
        step(v, P_DRAIN, 32'd5, 32'd2, "drain_3");
        v = idle(); v.dreq = 1'b1;
        step(v, P_FREEZE, 32'd5, 32'd2, "drain_frz3");
        step(v, P_FREEZE, 32'd5, 32'd2, "drain_frz4");
        v = idle();
        step(v, P_DRAIN, 32'd5, 32'd2, "drain_2");
        step(v, P_DRAIN, 32'd5, 32'd2, "drain_1");
        v = idle(); v.misp = 1'b1; v.dreq = 1'b1; v.halt = 1'b1;
        step(v, P_HALTED, 32'd5, 32'd2, "halted0");
        v = idle();
        step(v, P_HALTED, 32'd5, 32'd2, "halted1");

        // Reset leaves HALTED
        v = idle(); v.rst = 1'b0;
        step(v, P_RUN, 32'd0, 32'd0, "reset_halted");
        v = idle();
        step(v, P_RUN, 32'd0, 32'd0, "post_reset");

        // Reset mid-drain while drain_cnt == 2
        v = idle(); v.ecall = 1'b1; v.halt = 1'b1;
        step(v, P_HALTGO, 32'd0, 32'd0, "halt_go2");
        v = idle();
        step(v, P_DRAIN, 32'd1, 32'd0, "drain2_3");
        v = idle(); v.rst = 1'b0;
        step(v, P_RUN, 32'd0, 32'd0, "reset_mid_drain");
        v = idle();
        step(v, P_RUN, 32'd0, 32'd0, "after_drain_rst0");
        step(v, P_RUN, 32'd0, 32'd0, "after_drain_rst1");
        step(v, P_RUN, 32'd0, 32'd0, "after_drain_rst2");

        // Reset mid-freeze
        v = idle(); v.dreq = 1'b1;
        step(v, P_FREEZE, 32'd0, 32'd0, "run_frz1");
        step(v, P_FREEZE, 32'd1, 32'd0, "run_frz2");
        v = idle(); v.rst = 1'b0;
        step(v, P_RUN, 32'd0, 32'd0, "reset_mid_freeze");
        v = idle();
        step(v, P_RUN, 32'd0, 32'd0, "after_frz_rst");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_stall_controller

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core. It sits beside the forwarding logic and decides when the pipeline registers advance, stall, bubble or flush.
- Covers hazards forwarding cannot fix: load-use, ecall x17 reads from an in-flight load, branch mispredict flush, and data-cache freeze.
- Sequences the halt drain after a halting ecall and keeps saturating stall/flush counters for performance reporting.

Parameters:
- DRAIN_CYCLES, 3, cycles after halt ecall leaves ID before is_halted (EX, MEM, WB retire).
- CNT_WIDTH, 32, width of the performance counters.
- ECALL_REG, 17, register read by ecall in ID.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction really reads rs1/rs2.
- id_is_ecall  in  1  ID holds ecall.
- id_halt_req  in  1  ID ecall is a halt (x17==10 after forwarding).
- id_ex_rd  in  5  rd in EX.
- id_ex_mem_read  in  1  EX holds a load.
- id_ex_reg_write  in  1  EX writes rd.
- ex_mem_rd  in  5  rd in MEM.
- ex_mem_mem_read  in  1  MEM holds a load.
- ex_mispredict  in  1  EX branch/jump resolved wrong; redirect PC valid this cycle.
- dmem_req  in  1  MEM stage is accessing the data cache.
- dmem_ready  in  1  data cache completes the access this cycle.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID latch enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_write  out  1  ID/EX latch enable.
- id_ex_bubble  out  1  load NOP (control zeros) into ID/EX.
- ex_mem_write  out  1  EX/MEM latch enable.
- mem_wb_bubble  out  1  load NOP into MEM/WB.
- is_halted  out  1  core halted.
- stall_cycles  out  CNT_WIDTH  cycles with pc_write=0 in RUN state.
- flush_count  out  CNT_WIDTH  mispredict flushes taken.

Behaviour:
- Reset (reset=0, async): state=RUN, drain_cnt=0, counters=0. Outputs follow RUN with no hazard: all writes=1, all flush/bubble=0, is_halted=0.
- Hazard terms, evaluated combinationally:
  - freeze = dmem_req & !dmem_ready.
  - load_use = id_ex_mem_read & id_ex_rd!=0 & ((id_use_rs1 & id_rs1==id_ex_rd) | (id_use_rs2 & id_rs2==id_ex_rd)).
  - ecall_haz = id_is_ecall & ((id_ex_reg_write & id_ex_rd==ECALL_REG) | (ex_mem_mem_read & ex_mem_rd==ECALL_REG)).
  - A producer with rd=0 never causes a stall.
- RUN priority, highest first; outputs are combinational in the same cycle:
  1. freeze: pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_bubble=1. Mispredict and halt are ignored while frozen; EX holds, so they re-present next cycle.
  2. ex_mispredict: pc_write=1, if_id_flush=1, id_ex_bubble=1. flush_count+1.
  3. load_use | ecall_haz: pc_write=0, if_id_write=0, id_ex_bubble=1. Repeats each cycle until the hazard clears.
  4. id_halt_req: pc_write=0, if_id_flush=1, id_ex_write=1 so the ecall advances. Next state is DRAIN with drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - pc_write=0, if_id_flush=1, id_ex_bubble=1 every cycle.
  - ex_mispredict is ignored; no older branch can be in EX.
  - drain_cnt decrements each cycle without freeze. freeze applies the full freeze outputs and holds drain_cnt.
  - When drain_cnt==1 and the cycle is not frozen, next state is HALTED.
- HALTED: is_halted=1; all write enables 0; flush/bubble 0. Only reset leaves this state.
- Counters saturate at all-ones and never wrap. stall_cycles increments in RUN whenever pc_write=0. Counters hold in DRAIN and HALTED.
- Reset asserted mid-DRAIN or mid-freeze returns to RUN immediately and clears the counters.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - typedef ctrl_state_t {RUN, DRAIN, HALTED}.
  - constant ECALL_X17=17.
  - constant HALT_CODE=10.
- One sub-module, hazard_detect: purely combinational; produces load_use and ecall_haz. The FSM and counters stay in the top.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 (use_rs1=1). Expect 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then normal flow; stall_cycles=1.
- rd=0 and unused source: EX lw x0; ID rs1=0. Also EX lw x5 with ID use_rs2=0, rs2=5. Expect no stall in either case.
- Simultaneous mispredict and load-use in the same cycle: expect if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1, stall_cycles unchanged.
- Ecall hazard: ID ecall, MEM lw x17. Expect 1 stall cycle. With EX addi x17 instead, expect 1 stall cycle, then the ecall proceeds.
- Halt with freeze: id_halt_req, then freeze for 4 cycles during DRAIN. Expect is_halted asserted exactly 3 unfrozen cycles after leaving RUN (total 7), and pc_write=0 throughout.
- Reset mid-DRAIN: drop reset while drain_cnt=2. Expect state RUN, counters 0, and is_halted never asserted.
